// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester identifiers.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester winner selection; a tie goes to whichever requester did not win last.
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic req_cpu_i,
    input  logic req_dbg_i,
    input  logic last_i,
    output logic winner_o
);

    always_comb begin
        winner_o = REQ_CPU;
        if (req_cpu_i && req_dbg_i) begin
            winner_o = (last_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (req_dbg_i) begin
            winner_o = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug/loader access to one synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin ties; default build gives the CPU every tie.
//
// state  | meaning
// IDLE   | sample requests, latch winner's operands
// ACCESS | present latched operands to memory, pulse winner's gnt
// RESP   | read only: return mem_rdata with winner's rvalid
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_gnt_q, dbg_gnt_q;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              last_win;
    logic              winner;
    logic              accept;

    assign accept = (state_q == IDLE) && (cpu_req || dbg_req);

    arb_pick2 u_pick (
        .req_cpu_i (cpu_req),
        .req_dbg_i (dbg_req),
        .last_i    (last_win),
        .winner_o  (winner)
    );

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            last_q <= REQ_DBG;
        end else if (accept) begin
            last_q <= winner;
        end
    end

    assign last_win = last_q;
`else
    // Pretending DBG always won last makes every tie resolve to the CPU.
    assign last_win = REQ_DBG;
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q      <= IDLE;
            owner_q      <= REQ_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q   <= winner;
                        we_q      <= (winner == REQ_CPU) ? cpu_we    : dbg_we;
                        addr_q    <= (winner == REQ_CPU) ? cpu_addr  : dbg_addr;
                        wdata_q   <= (winner == REQ_CPU) ? cpu_wdata : dbg_wdata;
                        mem_we_q  <= (winner == REQ_CPU) ? cpu_we    : dbg_we;
                        cpu_gnt_q <= (winner == REQ_CPU);
                        dbg_gnt_q <= (winner == REQ_DBG);
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        cpu_rvalid_q <= (owner_q == REQ_CPU);
                        dbg_rvalid_q <= (owner_q == REQ_DBG);
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (owner_q == REQ_CPU) begin
                        cpu_rdata_q <= mem_rdata;
                    end else begin
                        dbg_rdata_q <= mem_rdata;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory data only arrives during RESP, so it is passed straight through then and held afterwards.
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid_q ? mem_rdata : dbg_rdata_q;
    assign cpu_gnt    = cpu_gnt_q;
    assign dbg_gnt    = dbg_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = mem_we_q;
    assign owner      = owner_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run against a timeline model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NR = 300;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dbg_rdata;
    logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic          mem_we, owner, busy;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem [0:255];

    int compared   = 0;
    int mismatched = 0;

    // Timeline model storage for the randomized run, indexed by cycle.
    logic          e_cg [0:NR+3];
    logic          e_dg [0:NR+3];
    logic          e_crv[0:NR+3];
    logic          e_drv[0:NR+3];
    logic          e_we [0:NR+3];
    logic          e_own[0:NR+3];
    logic [AW-1:0] e_addr[0:NR+3];
    logic [DW-1:0] e_wd [0:NR+3];
    logic [DW-1:0] e_dat[0:NR+3];
    logic [DW-1:0] ref_mem[0:15];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic apply_reset;
        cpu_req = 1'b0; dbg_req = 1'b0;
        Reset = 1'b0;
        tick(); tick();
        Reset = 1'b1;
    endtask

    task automatic test_reset;
        Reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h55;
        tick(); tick();
        compared++; if ({busy, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we} !== 6'b0) begin mismatched++; $display("FAIL reset_ctrl: got %b want 000000", {busy, cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we}); end
        compared++; if (owner !== 1'b0) begin mismatched++; $display("FAIL reset_owner: got %b want 0", owner); end
        compared++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0) begin mismatched++; $display("FAIL reset_mem_bus: got %h/%h want 00/0000", mem_addr, mem_wdata); end
        compared++; if (cpu_rdata !== 16'h0 || dbg_rdata !== 16'h0) begin mismatched++; $display("FAIL reset_rdata: got %h/%h want 0000/0000", cpu_rdata, dbg_rdata); end
        cpu_req = 1'b0;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        preload(8'h12, 16'hBEEF);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12; cpu_wdata = 16'h0;
        tick();
        compared++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin mismatched++; $display("FAIL read_gnt: got cpu=%b dbg=%b want 1/0", cpu_gnt, dbg_gnt); end
        compared++; if (mem_addr !== 8'h12 || mem_we !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL read_access: got addr=%h we=%b busy=%b want 12/0/1", mem_addr, mem_we, busy); end
        tick();
        cpu_req = 1'b0;
        compared++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin mismatched++; $display("FAIL read_rvalid: got v=%b d=%h want 1/beef", cpu_rvalid, cpu_rdata); end
        compared++; if (dbg_gnt !== 1'b0 || dbg_rvalid !== 1'b0 || dbg_rdata !== 16'h0 || cpu_gnt !== 1'b0) begin mismatched++; $display("FAIL read_dbg_quiet: got g=%b v=%b d=%h cg=%b want 0/0/0000/0", dbg_gnt, dbg_rvalid, dbg_rdata, cpu_gnt); end
        tick();
        compared++; if (cpu_rvalid !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 16'hBEEF) begin mismatched++; $display("FAIL read_done: got v=%b busy=%b d=%h want 0/0/beef", cpu_rvalid, busy, cpu_rdata); end
    endtask

    task automatic test_dbg_write;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h80; dbg_wdata = 16'h1234;
        tick();
        compared++; if (mem_we !== 1'b1 || mem_addr !== 8'h80 || mem_wdata !== 16'h1234) begin mismatched++; $display("FAIL dbgw_bus: got we=%b a=%h d=%h want 1/80/1234", mem_we, mem_addr, mem_wdata); end
        compared++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0 || owner !== 1'b1) begin mismatched++; $display("FAIL dbgw_gnt: got dg=%b cg=%b own=%b want 1/0/1", dbg_gnt, cpu_gnt, owner); end
        tick();
        dbg_req = 1'b0;
        compared++; if (mem_we !== 1'b0 || busy !== 1'b0 || dbg_rvalid !== 1'b0 || dbg_gnt !== 1'b0) begin mismatched++; $display("FAIL dbgw_end: got we=%b busy=%b rv=%b g=%b want 0/0/0/0", mem_we, busy, dbg_rvalid, dbg_gnt); end
        compared++; if (mem[8'h80] !== 16'h1234) begin mismatched++; $display("FAIL dbgw_mem: got %h want 1234", mem[8'h80]); end
        tick();
        compared++; if (dbg_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin mismatched++; $display("FAIL dbgw_after: got rv=%b cpu_rdata=%h want 0/beef", dbg_rvalid, cpu_rdata); end
    endtask

    task automatic test_req_drop;
        preload(8'h33, 16'h5A5A);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        tick();
        compared++; if (cpu_gnt !== 1'b1) begin mismatched++; $display("FAIL drop_gnt: got %b want 1", cpu_gnt); end
        cpu_req = 1'b0; cpu_addr = 8'hFF;
        tick();
        compared++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h5A5A || mem_addr !== 8'h33) begin mismatched++; $display("FAIL drop_rvalid: got v=%b d=%h a=%h want 1/5a5a/33", cpu_rvalid, cpu_rdata, mem_addr); end
        tick();
        compared++; if (busy !== 1'b0 || cpu_rvalid !== 1'b0) begin mismatched++; $display("FAIL drop_idle: got busy=%b v=%b want 0/0", busy, cpu_rvalid); end
    endtask

    task automatic test_back_to_back;
        int ngnt = 0;
        int nwe  = 0;
        logic exp_g;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h40; cpu_wdata = 16'hA5A5;
        for (int j = 1; j <= 10; j++) begin
            tick();
            exp_g = (j % 2 == 1);
            if (cpu_gnt === 1'b1) ngnt++;
            if (mem_we === 1'b1) nwe++;
            compared++; if (cpu_gnt !== exp_g || mem_we !== exp_g) begin mismatched++; $display("FAIL b2b_cycle%0d: got gnt=%b we=%b want %b", j, cpu_gnt, mem_we, exp_g); end
        end
        cpu_req = 1'b0;
        compared++; if (ngnt != 5 || nwe != 5) begin mismatched++; $display("FAIL b2b_count: got gnt=%0d we=%0d want 5/5", ngnt, nwe); end
        tick();
        compared++; if (mem[8'h40] !== 16'hA5A5 || busy !== 1'b0) begin mismatched++; $display("FAIL b2b_mem: got %h busy=%b want a5a5/0", mem[8'h40], busy); end
    endtask

    task automatic test_reset_abort;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h21; cpu_wdata = 16'h7777;
        tick();
        compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL abort_pre: got we=%b want 1", mem_we); end
        Reset = 1'b0;
        tick();
        compared++; if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_gnt !== 1'b0) begin mismatched++; $display("FAIL abort_edge: got we=%b busy=%b g=%b want 0/0/0", mem_we, busy, cpu_gnt); end
        tick();
        compared++; if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_gnt !== 1'b0) begin mismatched++; $display("FAIL abort_held: got we=%b busy=%b g=%b want 0/0/0", mem_we, busy, cpu_gnt); end
        Reset = 1'b1;
        tick();
        compared++; if (cpu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h21) begin mismatched++; $display("FAIL abort_reaccept: got g=%b we=%b a=%h want 1/1/21", cpu_gnt, mem_we, mem_addr); end
        cpu_req = 1'b0;
        tick();
        compared++; if (busy !== 1'b0 || mem_we !== 1'b0) begin mismatched++; $display("FAIL abort_done: got busy=%b we=%b want 0/0", busy, mem_we); end
    endtask

    task automatic test_tie;
        int seq[$];
        int ndbg = 0;
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h06;
        for (int j = 1; j <= 12; j++) begin
            tick();
            compared++; if (cpu_gnt === 1'b1 && dbg_gnt === 1'b1) begin mismatched++; $display("FAIL tie_double_gnt: cycle %0d both granted", j); end
            if (cpu_gnt === 1'b1) seq.push_back(0);
            if (dbg_gnt === 1'b1) begin seq.push_back(1); ndbg++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        compared++; if (seq.size() != 4) begin mismatched++; $display("FAIL tie_count: got %0d grants want 4", seq.size()); end
        for (int i = 0; i < seq.size() && i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
            compared++; if (seq[i] != i % 2) begin mismatched++; $display("FAIL tie_order%0d: got %0d want %0d", i, seq[i], i % 2); end
`else
            compared++; if (seq[i] != 0) begin mismatched++; $display("FAIL tie_order%0d: got %0d want 0", i, seq[i]); end
`endif
        end
`ifndef DMEM_ARB_RR_EN
        compared++; if (ndbg != 0) begin mismatched++; $display("FAIL tie_starve: got %0d dbg grants want 0", ndbg); end
`endif
        tick(); tick(); tick();
    endtask

    task automatic test_random;
        int   free_at = 0;
        logic last = 1'b1;
        logic c_drop = 1'b0, d_drop = 1'b0;
        logic [DW-1:0] exp_cd = '0, exp_dd = '0;
        logic win, w_we;
        logic [AW-1:0] w_a;
        logic [DW-1:0] w_d;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 16'($urandom);
            preload(8'(i), ref_mem[i]);
        end
        for (int i = 0; i <= NR + 3; i++) begin
            e_cg[i] = 0; e_dg[i] = 0; e_crv[i] = 0; e_drv[i] = 0; e_we[i] = 0;
            e_own[i] = 0; e_addr[i] = '0; e_wd[i] = '0; e_dat[i] = '0;
        end
        for (int k = 0; k < NR; k++) begin
            if (e_crv[k]) exp_cd = e_dat[k];
            if (e_drv[k]) exp_dd = e_dat[k];
            compared++; if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we} !== {e_cg[k], e_dg[k], e_crv[k], e_drv[k], e_we[k]}) begin mismatched++; $display("FAIL rnd_ctrl@%0d: got %b want %b", k, {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_we}, {e_cg[k], e_dg[k], e_crv[k], e_drv[k], e_we[k]}); end
            compared++; if (busy !== (k < free_at)) begin mismatched++; $display("FAIL rnd_busy@%0d: got %b want %b", k, busy, (k < free_at)); end
            compared++; if (cpu_rdata !== exp_cd || dbg_rdata !== exp_dd) begin mismatched++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", k, cpu_rdata, dbg_rdata, exp_cd, exp_dd); end
            if (e_cg[k] || e_dg[k]) begin
                compared++; if (mem_addr !== e_addr[k] || owner !== e_own[k]) begin mismatched++; $display("FAIL rnd_addr@%0d: got %h own=%b want %h own=%b", k, mem_addr, owner, e_addr[k], e_own[k]); end
            end
            if (e_we[k]) begin
                compared++; if (mem_wdata !== e_wd[k]) begin mismatched++; $display("FAIL rnd_wdata@%0d: got %h want %h", k, mem_wdata, e_wd[k]); end
            end
            if (c_drop) begin cpu_req = 0; c_drop = 0; end
            else if (cpu_req && e_cg[k]) c_drop = 1;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 8'($urandom_range(0, 15)); cpu_wdata = 16'($urandom);
            end
            if (d_drop) begin dbg_req = 0; d_drop = 0; end
            else if (dbg_req && e_dg[k]) d_drop = 1;
            else if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_req = 1; dbg_we = 1'($urandom_range(0, 1)); dbg_addr = 8'($urandom_range(0, 15)); dbg_wdata = 16'($urandom);
            end
            if (k >= free_at && (cpu_req || dbg_req)) begin
`ifdef DMEM_ARB_RR_EN
                if (cpu_req && dbg_req) win = ~last;
`else
                if (cpu_req && dbg_req) win = 1'b0;
`endif
                else win = dbg_req;
                last = win;
                w_we = win ? dbg_we : cpu_we;
                w_a  = win ? dbg_addr : cpu_addr;
                w_d  = win ? dbg_wdata : cpu_wdata;
                e_cg[k+1] = ~win; e_dg[k+1] = win; e_own[k+1] = win;
                e_addr[k+1] = w_a; e_we[k+1] = w_we; e_wd[k+1] = w_d;
                if (w_we) begin
                    ref_mem[w_a[3:0]] = w_d;
                    free_at = k + 2;
                end else begin
                    e_crv[k+2] = ~win; e_drv[k+2] = win;
                    e_dat[k+2] = ref_mem[w_a[3:0]];
                    free_at = k + 3;
                end
            end
            tick();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        Reset = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        test_reset();
        test_single_read();
        test_dbg_write();
        test_req_drop();
        test_back_to_back();
        test_reset_abort();
        test_tie();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 8, data memory address width.
- REQ-002 Parameter DATA_W, default 16, data memory word width.
- REQ-003 Clock  input  1  rising-edge clock; Reset  input  1  synchronous, active-low reset.
- REQ-004 cpu_req, cpu_we  input  1  control-unit request and write-enable; cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W.
- REQ-005 cpu_gnt  output  1  request accepted; cpu_rvalid  output  1  read data valid; cpu_rdata  output  DATA_W.
- REQ-006 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata SHALL mirror the cpu_* ports for the debug/loader requester.
- REQ-007 mem_addr  output  ADDR_W; mem_we  output  1; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  (memory read data is valid one cycle after the address is presented).
- REQ-008 owner  output  1  current transaction owner (0 = CPU, 1 = DBG); busy  output  1  high whenever state != IDLE.

Function
- REQ-009 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
- REQ-010 IDLE: if any req is high, latch the winner's addr/we/wdata, record the winner in owner, and go to ACCESS; otherwise stay in IDLE.
- REQ-011 ACCESS: drive mem_addr/mem_wdata from the latched values, drive mem_we equal to the latched we, pulse the winner's gnt for exactly one cycle, then go to RESP for a read or to IDLE for a write.
- REQ-012 RESP: pulse the winner's rvalid for one cycle with rdata = mem_rdata, then go to IDLE.
- REQ-013 Latency: a read sampled in IDLE at cycle N SHALL give gnt at N+1 and rvalid at N+2; a write SHALL give gnt and mem_we at N+1.
- REQ-014 Requests SHALL be sampled only in IDLE; a requester holds req until it sees gnt and deasserts req in the cycle after gnt.
- REQ-015 Latched operands SHALL NOT change during ACCESS or RESP; deassertion of req after acceptance SHALL NOT abort the transaction.
- REQ-016 Tie rule (both req in IDLE): as defined in REQ-021/REQ-022; a single requester always wins.
- REQ-017 The non-owner's gnt and rvalid SHALL remain 0, and its rdata SHALL hold its last value.
- REQ-018 mem_we SHALL be high only in ACCESS with a latched write; mem_addr SHALL carry no wrap or offset, passing the address through unchanged.

Reset
- REQ-019 When Reset=0 at a rising edge: state=IDLE; all gnt, rvalid, mem_we and busy = 0; mem_addr, mem_wdata and rdata = 0; owner = 0; last-winner register = DBG.
- REQ-020 Reset asserted in ACCESS or RESP SHALL abort the transaction: no mem_we pulse and no rvalid pulse after the reset edge.

Configuration
- REQ-021 With DMEM_ARB_RR_EN defined: round-robin arbitration. On a tie, the requester that is not the last winner wins, and the last-winner register updates on every grant.
- REQ-022 Without DMEM_ARB_RR_EN: fixed priority, with CPU winning every tie; the last-winner register is absent.

Structure
- REQ-023 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP) and the requester-id enum (REQ_CPU=0, REQ_DBG=1).
- REQ-024 A single sub-module arb_pick2 SHALL implement winner selection (inputs: two reqs and last winner; output: winner id).

Verification
- REQ-025 Single CPU read of addr 0x12 while mem holds 0xBEEF: cpu_gnt at N+1, cpu_rvalid at N+2 with cpu_rdata=0xBEEF, dbg outputs stay 0.
- REQ-026 DBG write of 0x1234 to 0x80: mem_we=1, mem_addr=0x80, mem_wdata=0x1234 for exactly one cycle at N+1; returns to IDLE at N+2, with no rvalid pulse.
- REQ-027 Both req held continuously with reads, RR enabled: grants alternate CPU, DBG, CPU, DBG. With RR disabled: the CPU is granted every time and DBG is starved while cpu_req stays high.
- REQ-028 Reset=0 asserted in the ACCESS cycle of a write: mem_we=0 after the edge, busy=0, state IDLE, and the pending request is re-accepted only after Reset returns to 1.
- REQ-029 cpu_req dropped in the ACCESS cycle of a read: the transaction still completes, with cpu_rvalid at N+2 and correct data.
- REQ-030 Back-to-back CPU writes with req held: one gnt every 2 cycles, with no duplicate mem_we for a single request.
